// File: rtl/mdu_sequencer.sv
// Multi-cycle MUL/MULHU/DIVU/REMU sequencer driving the shared E-stage ALU.
// Define MDU_SIGNED_EN to add signed MULH/DIV/REM with a one-cycle FIX step.
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
`ifdef MDU_SIGNED_EN
  input  logic [2:0]       MdOpE,
`else
  input  logic [1:0]       MdOpE,
`endif
  input  logic [WIDTH-1:0] Op1E,
  input  logic [WIDTH-1:0] Op2E,
  output logic [3:0]       SeqALUCtrl,
  output logic [WIDTH-1:0] SeqOp1,
  output logic [WIDTH-1:0] SeqOp2,
  input  logic [WIDTH-1:0] SeqALURes,
  input  logic             SeqALUCarry,
  output logic             BusyE,
  output logic             DoneE,
  output logic [WIDTH-1:0] ResultE
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef MDU_SIGNED_EN
  localparam int OP_W = 3;
`else
  localparam int OP_W = 2;
`endif

`ifdef MDU_SIGNED_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, FIX = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2
  } state_t;
`endif

  state_t           state, state_n;
  logic [OP_W-1:0]  op, op_n;
  logic [WIDTH-1:0] hi, hi_n;
  logic [WIDTH-1:0] lo, lo_n;
  logic [WIDTH-1:0] dv, dv_n;
  logic [WIDTH-1:0] res, res_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] rem_s;
  logic             qbit;
  logic [WIDTH-1:0] mag1, mag2;
  logic             last;

  assign rem_s = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign qbit  = hi[WIDTH-1] | ~SeqALUCarry;
  assign last  = (cnt == CNT_W'(WIDTH - 1));

`ifdef MDU_SIGNED_EN
  logic             neg_q, neg_q_n;
  logic             neg_r, neg_r_n;
  logic             fix_neg;
  logic [WIDTH-1:0] fix_val;

  assign mag1 = (MdOpE[2] && Op1E[WIDTH-1]) ? -Op1E : Op1E;
  assign mag2 = (MdOpE[2] && Op2E[WIDTH-1]) ? -Op2E : Op2E;
  assign fix_neg = (op[1] && op[0]) ? neg_r : neg_q;
  assign fix_val = op[0] ? hi : lo;
`else
  assign mag1 = Op1E;
  assign mag2 = Op2E;
`endif

  assign BusyE   = (state == RUN)
`ifdef MDU_SIGNED_EN
                 | (state == FIX)
`endif
                 ;
  assign DoneE   = (state == DONE);
  assign ResultE = res;

  // ALU operand drive depends only on registered state, never on ALU outputs
  always_comb begin
    SeqALUCtrl = 4'b0000;
    SeqOp1     = '0;
    SeqOp2     = '0;
    case (state)
      RUN: begin
        if (op[1]) begin
          SeqALUCtrl = 4'b0001;
          SeqOp1     = rem_s;
          SeqOp2     = dv;
        end else begin
          SeqOp1 = hi;
          SeqOp2 = lo[0] ? dv : '0;
        end
      end
`ifdef MDU_SIGNED_EN
      // high half of a negated product borrows once when low half is nonzero
      FIX: begin
        if (fix_neg) begin
          SeqALUCtrl = 4'b0001;
          SeqOp1     = (!op[1] && op[0] && lo != '0) ? '1 : '0;
          SeqOp2     = fix_val;
        end
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    op_n    = op;
    hi_n    = hi;
    lo_n    = lo;
    dv_n    = dv;
    res_n   = res;
    cnt_n   = cnt;
`ifdef MDU_SIGNED_EN
    neg_q_n = neg_q;
    neg_r_n = neg_r;
`endif
    case (state)
      IDLE: begin
        if (StartE) begin
          op_n  = MdOpE;
          hi_n  = '0;
          cnt_n = '0;
          lo_n  = MdOpE[1] ? mag1 : mag2;
          dv_n  = MdOpE[1] ? mag2 : mag1;
`ifdef MDU_SIGNED_EN
          neg_q_n = MdOpE[2] & (Op1E[WIDTH-1] ^ Op2E[WIDTH-1]);
          neg_r_n = MdOpE[2] & Op1E[WIDTH-1];
`endif
          if (MdOpE[1] && Op2E == '0) begin
            state_n = DONE;
            res_n   = MdOpE[0] ? Op1E : '1;
          end else begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        cnt_n = cnt + 1'b1;
        if (op[1]) begin
          hi_n = qbit ? SeqALURes : rem_s;
          lo_n = {lo[WIDTH-2:0], qbit};
        end else begin
          {hi_n, lo_n} = {SeqALUCarry, SeqALURes, lo[WIDTH-1:1]};
        end
        if (last) begin
          res_n   = op[0] ? hi_n : lo_n;
          state_n = DONE;
`ifdef MDU_SIGNED_EN
          if (op[2]) state_n = FIX;
`endif
        end
      end
`ifdef MDU_SIGNED_EN
      FIX: begin
        res_n   = fix_neg ? SeqALURes : fix_val;
        state_n = DONE;
      end
`endif
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op    <= '0;
      hi    <= '0;
      lo    <= '0;
      dv    <= '0;
      res   <= '0;
      cnt   <= '0;
`ifdef MDU_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      state <= state_n;
      op    <= op_n;
      hi    <= hi_n;
      lo    <= lo_n;
      dv    <= dv_n;
      res   <= res_n;
      cnt   <= cnt_n;
`ifdef MDU_SIGNED_EN
      neg_q <= neg_q_n;
      neg_r <= neg_r_n;
`endif
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer (unsigned build) with a behavioural ALU.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        StartE;
  logic [1:0]  MdOpE;
  logic [31:0] Op1E, Op2E;
  logic [3:0]  SeqALUCtrl;
  logic [31:0] SeqOp1, SeqOp2;
  logic [31:0] SeqALURes;
  logic        SeqALUCarry;
  logic        BusyE, DoneE;
  logic [31:0] ResultE;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_sequencer #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .StartE(StartE),
    .MdOpE(MdOpE),
    .Op1E(Op1E),
    .Op2E(Op2E),
    .SeqALUCtrl(SeqALUCtrl),
    .SeqOp1(SeqOp1),
    .SeqOp2(SeqOp2),
    .SeqALURes(SeqALURes),
    .SeqALUCarry(SeqALUCarry),
    .BusyE(BusyE),
    .DoneE(DoneE),
    .ResultE(ResultE)
  );

  // sub reports borrow in the carry bit
  always_comb begin
    if (SeqALUCtrl == 4'b0001)
      {SeqALUCarry, SeqALURes} = {1'b0, SeqOp1} - {1'b0, SeqOp2};
    else
      {SeqALUCarry, SeqALURes} = {1'b0, SeqOp1} + {1'b0, SeqOp2};
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat,
                        input int exp_busy, input logic [3:0] exp_ctrl);
    int lat;
    int busy;
    logic [3:0] ctrl1;
    @(negedge clk);
    StartE = 1'b1;
    MdOpE  = op;
    Op1E   = a;
    Op2E   = b;
    @(negedge clk);
    StartE = 1'b0;
    lat    = 1;
    busy   = 0;
    ctrl1  = SeqALUCtrl;
    while (!DoneE && lat < 200) begin
      busy += int'(BusyE);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    chk({tag, "_ctrl"}, 32'(ctrl1), 32'(exp_ctrl));
    chk({tag, "_res"}, ResultE, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(DoneE), 32'd0);
    chk({tag, "_hold"}, ResultE, exp);
  endtask

  initial begin
    int lat;
    reset  = 1'b1;
    StartE = 1'b0;
    MdOpE  = 2'b00;
    Op1E   = '0;
    Op2E   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(BusyE), 32'd0);
    chk("rst_done", 32'(DoneE), 32'd0);
    chk("rst_res", ResultE, 32'd0);
    chk("rst_op1", SeqOp1, 32'd0);
    chk("rst_ctrl", 32'(SeqALUCtrl), 32'd0);
    reset = 1'b0;

    run_op("mul7x6", 2'b00, 32'd7, 32'd6, 32'd42, 33, 32, 4'b0000);
    run_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 33, 32, 4'b0000);
    run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h0000_0001, 33, 32, 4'b0000);
    run_op("mul_zero", 2'b00, 32'h1234_5678, 32'd0, 32'd0, 33, 32, 4'b0000);
    run_op("divu100_7", 2'b10, 32'd100, 32'd7, 32'd14, 33, 32, 4'b0001);
    run_op("remu100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33, 32, 4'b0001);
    run_op("divu_max1", 2'b10, 32'hFFFF_FFFF, 32'd1,
           32'hFFFF_FFFF, 33, 32, 4'b0001);
    run_op("divu_maxmax", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'd1, 33, 32, 4'b0001);
    run_op("remu7_100", 2'b11, 32'd7, 32'd100, 32'd7, 33, 32, 4'b0001);
    run_op("divu_by0", 2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 4'b0000);
    run_op("remu_by0", 2'b11, 32'd5, 32'd0, 32'd5, 1, 0, 4'b0000);

    // reset while RUN with cnt == 10
    @(negedge clk);
    StartE = 1'b1;
    MdOpE  = 2'b00;
    Op1E   = 32'd100;
    Op2E   = 32'd100;
    @(negedge clk);
    StartE = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy_pre", 32'(BusyE), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_busy", 32'(BusyE), 32'd0);
    chk("mid_done", 32'(DoneE), 32'd0);
    chk("mid_res", ResultE, 32'd0);
    run_op("mul3x3", 2'b00, 32'd3, 32'd3, 32'd9, 33, 32, 4'b0000);

    // StartE held high; operand changes during the op must be ignored
    @(negedge clk);
    StartE = 1'b1;
    MdOpE  = 2'b00;
    Op1E   = 32'd5;
    Op2E   = 32'd4;
    @(negedge clk);
    lat = 1;
    while (!DoneE && lat < 200) begin
      Op1E = 32'(lat) + 32'd100;
      @(negedge clk);
      lat++;
    end
    chk("held1_lat", 32'(lat), 32'd33);
    chk("held1_res", ResultE, 32'd20);
    Op1E = 32'd11;
    Op2E = 32'd2;
    @(negedge clk);
    lat = 1;
    chk("held_idle_busy", 32'(BusyE), 32'd0);
    while (!DoneE && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    StartE = 1'b0;
    chk("held2_lat", 32'(lat), 32'd34);
    chk("held2_res", ResultE, 32'd22);
    @(negedge clk);
    chk("held2_pulse", 32'(DoneE), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
